// File: rtl/matmul_job_scheduler.sv
// rtl/matmul_job_scheduler.sv - job queue and sequencer for the tiled-matmul tile controller
//
// Accepts job descriptors into a circular FIFO, pops one at a time into the
// cfg_* registers, validates the dimensions, drives tile_req while the tile
// controller works, and returns one completion record per job.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   job_valid/job_ready, job_*    descriptor push interface (job_ready = !full)
//   cfg_*                         per-job configuration held for the tile controller
//   tile_req                      level request, high only while a job runs
//   start_tile, done_all          controller pulses, only observed while running
//   cmp_valid/cmp_ready, cmp_*    completion record (id, err, tile count)
//   q_level, busy                 queue occupancy and not-idle status

module matmul_job_scheduler #(
   parameter int ADDR_WIDTH = 32,
   parameter int IDX_WIDTH  = 8,
   parameter int ID_WIDTH   = 4,
   parameter int DEPTH      = 4,
   parameter int TIMEOUT    = 1024
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        job_valid,
   output logic                        job_ready,
   input  logic [ID_WIDTH-1:0]         job_id,
   input  logic [IDX_WIDTH-1:0]        job_M,
   input  logic [IDX_WIDTH-1:0]        job_N,
   input  logic [IDX_WIDTH-1:0]        job_K,
   input  logic [IDX_WIDTH-1:0]        job_TM,
   input  logic [IDX_WIDTH-1:0]        job_TN,
   input  logic [IDX_WIDTH-1:0]        job_TK,
   input  logic [ADDR_WIDTH-1:0]       job_baseA,
   input  logic [ADDR_WIDTH-1:0]       job_baseB,
   input  logic [ADDR_WIDTH-1:0]       job_baseC,
   output logic [IDX_WIDTH-1:0]        cfg_M,
   output logic [IDX_WIDTH-1:0]        cfg_N,
   output logic [IDX_WIDTH-1:0]        cfg_K,
   output logic [IDX_WIDTH-1:0]        cfg_TM,
   output logic [IDX_WIDTH-1:0]        cfg_TN,
   output logic [IDX_WIDTH-1:0]        cfg_TK,
   output logic [ADDR_WIDTH-1:0]       cfg_baseA,
   output logic [ADDR_WIDTH-1:0]       cfg_baseB,
   output logic [ADDR_WIDTH-1:0]       cfg_baseC,
   output logic                        tile_req,
   input  logic                        start_tile,
   input  logic                        done_all,
   output logic                        cmp_valid,
   input  logic                        cmp_ready,
   output logic [ID_WIDTH-1:0]         cmp_id,
   output logic [1:0]                  cmp_err,
   output logic [3*IDX_WIDTH-1:0]      cmp_tiles,
   output logic [$clog2(DEPTH):0]      q_level,
   output logic                        busy
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam int TW = 3 * IDX_WIDTH;
   // Idle counter only has to reach TIMEOUT-1.
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int DW = ID_WIDTH + 6 * IDX_WIDTH + 3 * ADDR_WIDTH;
   localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
   localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CHECK,
      S_RUN,
      S_REPORT
   } state_t;

   state_t state, state_next;

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] count;
   logic [TW-1:0] tile_cnt;
   logic [CW-1:0] idle_cnt;
   logic [1:0]    err;

   logic full, push, pop, cfg_bad, run_event, timeout_hit;

   assign full        = (count == FULL_LVL);
   assign push        = job_valid && !full;
   assign pop         = (state == S_IDLE) && (count != '0);
   assign cfg_bad     = (cfg_M == '0) || (cfg_N == '0) || (cfg_K == '0) ||
                        (cfg_TM == '0) || (cfg_TN == '0) || (cfg_TK == '0);
   assign run_event   = start_tile || done_all;
   // done_all wins over a timeout landing in the same cycle.
   assign timeout_hit = !run_event && (idle_cnt == IDLE_LAST);

   assign job_ready = !full;
   assign q_level   = count;
   assign tile_req  = (state == S_RUN);
   assign cmp_valid = (state == S_REPORT);
   assign busy      = (state != S_IDLE);
   assign cmp_tiles = tile_cnt;
   assign cmp_err   = err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (pop) state_next = S_CHECK;
         S_CHECK:  state_next = cfg_bad ? S_REPORT : S_RUN;
         S_RUN:    if (done_all || timeout_hit) state_next = S_REPORT;
         S_REPORT: if (cmp_ready) state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // Descriptor storage is not reset; only pointers and count define contents.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {job_id, job_M, job_N, job_K, job_TM, job_TN, job_TK,
                         job_baseA, job_baseB, job_baseC};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         cmp_id    <= '0;
         cfg_M     <= '0;
         cfg_N     <= '0;
         cfg_K     <= '0;
         cfg_TM    <= '0;
         cfg_TN    <= '0;
         cfg_TK    <= '0;
         cfg_baseA <= '0;
         cfg_baseB <= '0;
         cfg_baseC <= '0;
         tile_cnt  <= '0;
         idle_cnt  <= '0;
         err       <= 2'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            {cmp_id, cfg_M, cfg_N, cfg_K, cfg_TM, cfg_TN, cfg_TK,
             cfg_baseA, cfg_baseB, cfg_baseC} <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         case (state)
            S_CHECK: begin
               // Clearing here also gives a bad-config record a zero tile count.
               tile_cnt <= '0;
               idle_cnt <= '0;
               err      <= cfg_bad ? 2'd1 : 2'd0;
            end
            S_RUN: begin
               if (start_tile && (tile_cnt != {TW{1'b1}}))
                  tile_cnt <= tile_cnt + 1'b1;
               if (run_event) idle_cnt <= '0;
               else if (!timeout_hit) idle_cnt <= idle_cnt + 1'b1;
               if (done_all)         err <= 2'd0;
               else if (timeout_hit) err <= 2'd2;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_job_scheduler.sv
// tb/tb_matmul_job_scheduler.sv - scoreboard bench for matmul_job_scheduler

module tb_matmul_job_scheduler;

   localparam int AW = 32;
   localparam int IW = 8;
   localparam int DW = 4;
   localparam int DEPTH = 4;
   localparam int TO = 16;

   logic clk = 0;
   logic rst = 1;
   logic job_valid = 0;
   logic job_ready;
   logic [DW-1:0] job_id = '0;
   logic [IW-1:0] job_M = '0, job_N = '0, job_K = '0, job_TM = '0, job_TN = '0, job_TK = '0;
   logic [AW-1:0] job_baseA = '0, job_baseB = '0, job_baseC = '0;
   logic [IW-1:0] cfg_M, cfg_N, cfg_K, cfg_TM, cfg_TN, cfg_TK;
   logic [AW-1:0] cfg_baseA, cfg_baseB, cfg_baseC;
   logic tile_req;
   logic start_tile = 0;
   logic done_all = 0;
   logic cmp_valid;
   logic cmp_ready = 0;
   logic [DW-1:0] cmp_id;
   logic [1:0] cmp_err;
   logic [3*IW-1:0] cmp_tiles;
   logic [$clog2(DEPTH):0] q_level;
   logic busy;

   matmul_job_scheduler #(
      .ADDR_WIDTH(AW), .IDX_WIDTH(IW), .ID_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .job_valid(job_valid), .job_ready(job_ready), .job_id(job_id),
      .job_M(job_M), .job_N(job_N), .job_K(job_K),
      .job_TM(job_TM), .job_TN(job_TN), .job_TK(job_TK),
      .job_baseA(job_baseA), .job_baseB(job_baseB), .job_baseC(job_baseC),
      .cfg_M(cfg_M), .cfg_N(cfg_N), .cfg_K(cfg_K),
      .cfg_TM(cfg_TM), .cfg_TN(cfg_TN), .cfg_TK(cfg_TK),
      .cfg_baseA(cfg_baseA), .cfg_baseB(cfg_baseB), .cfg_baseC(cfg_baseC),
      .tile_req(tile_req), .start_tile(start_tile), .done_all(done_all),
      .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_id(cmp_id),
      .cmp_err(cmp_err), .cmp_tiles(cmp_tiles), .q_level(q_level), .busy(busy)
   );

   always #5 clk = ~clk;

   // kind: 0 = n tiles then done_all, 1 = silent (timeout), 2 = done_all on the timeout cycle
   typedef struct {
      logic [DW-1:0] id;
      logic [IW-1:0] m, n, k, tm, tn, tk;
      logic [AW-1:0] a, b, c;
      int kind;
      int ntiles;
      int gap;
   } job_t;

   typedef struct {
      logic [DW-1:0]   id;
      logic [1:0]      err;
      logic [3*IW-1:0] tiles;
   } rec_t;

   job_t plan_q[$];
   rec_t exp_q[$];
   int checks = 0;
   int errors = 0;
   bit ctrl_en = 1;
   bit hold_low = 0;
   bit saw_full = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic job_t make_job(input int kind, input int n, input int gap, input bit bad);
      job_t j;
      j.id = DW'($urandom);
      j.m  = IW'($urandom_range(1, 255));
      j.n  = IW'($urandom_range(1, 255));
      j.k  = IW'($urandom_range(1, 255));
      j.tm = IW'($urandom_range(1, 255));
      j.tn = IW'($urandom_range(1, 255));
      j.tk = IW'($urandom_range(1, 255));
      j.a  = $urandom;
      j.b  = $urandom;
      j.c  = $urandom;
      if (bad) begin
         case ($urandom_range(0, 5))
            0: j.m = '0;
            1: j.n = '0;
            2: j.k = '0;
            3: j.tm = '0;
            4: j.tn = '0;
            default: j.tk = '0;
         endcase
      end
      j.kind = kind;
      j.ntiles = n;
      j.gap = gap;
      return j;
   endfunction

   // Reference model: what record each accepted job must produce.
   task automatic model_accept(input job_t j);
      rec_t r;
      bit bad;
      bad = (j.m == 0) || (j.n == 0) || (j.k == 0) || (j.tm == 0) || (j.tn == 0) || (j.tk == 0);
      r.id = j.id;
      if (bad) begin
         r.err = 2'd1;
         r.tiles = '0;
      end else begin
         r.err = (j.kind == 1) ? 2'd2 : 2'd0;
         r.tiles = (j.kind == 0) ? (3*IW)'(j.ntiles) : '0;
         plan_q.push_back(j);
      end
      exp_q.push_back(r);
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge, job_valid left high.
   task automatic push_job(input job_t j, input bit modeled);
      int t;
      bit stalled;
      t = 0;
      stalled = 0;
      job_valid = 1;
      job_id = j.id;
      job_M = j.m; job_N = j.n; job_K = j.k;
      job_TM = j.tm; job_TN = j.tn; job_TK = j.tk;
      job_baseA = j.a; job_baseB = j.b; job_baseC = j.c;
      forever begin
         @(negedge clk);
         if (job_ready) begin
            if (modeled) model_accept(j);
            @(posedge clk); #1;
            break;
         end
         if (!stalled) begin
            check("full_q_level", 64'(q_level), 64'(DEPTH));
            stalled = 1;
            saw_full = 1;
         end
         t++;
         if (t > 2000) begin
            check("push_timeout", 64'(job_ready), 64'd1);
            job_valid = 0;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic idle_cycles(input int n);
      job_valid = 0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      job_valid = 0;
      while (exp_q.size() != 0 && t < 5000) begin
         @(negedge clk);
         t++;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   task automatic drv(input logic s, input logic d);
      @(posedge clk); #1;
      start_tile = s;
      done_all = d;
   endtask

   // Tile-controller model, entered at the negedge of the first RUN cycle.
   task automatic run_plan(input job_t j);
      int cnt;
      check("cfg_dims", 64'({cfg_M, cfg_N, cfg_K, cfg_TM, cfg_TN, cfg_TK}),
            64'({j.m, j.n, j.k, j.tm, j.tn, j.tk}));
      check("cfg_baseAB", {cfg_baseA, cfg_baseB}, {j.a, j.b});
      check("cfg_baseC", 64'(cfg_baseC), 64'(j.c));
      case (j.kind)
         0: begin
            for (int i = 0; i < j.ntiles; i++) begin
               repeat (j.gap) drv(0, 0);
               drv(1, 0);
            end
            repeat (j.gap) drv(0, 0);
            drv(0, 1);
            drv(0, 0);
         end
         1: begin
            cnt = 1;
            forever begin
               @(negedge clk);
               if (!tile_req || cnt > 100) break;
               cnt++;
            end
            check("timeout_len", 64'(cnt), 64'(TO));
         end
         default: begin
            // Cycle 1 was observed; the k-th drv sets cycle k+1, so this lands on cycle TO.
            repeat (TO - 2) drv(0, 0);
            drv(0, 1);
            drv(0, 0);
         end
      endcase
      // Pulses outside RUN must be ignored.
      drv(1, 1);
      drv(0, 0);
   endtask

   initial begin : controller
      int t;
      forever begin
         @(negedge clk);
         if (ctrl_en && tile_req && !rst) begin
            if (plan_q.size() == 0) begin
               check("unexpected_run", 64'(tile_req), 64'd0);
               t = 0;
               while (tile_req && t < 100) begin
                  @(negedge clk);
                  t++;
               end
            end else begin
               run_plan(plan_q.pop_front());
            end
         end
      end
   end

   initial begin : host_ready
      forever begin
         @(posedge clk); #1;
         cmp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   initial begin : monitor
      rec_t e;
      logic prev_valid, prev_ready;
      logic [DW+2+3*IW-1:0] prev_rec;
      prev_valid = 0;
      prev_ready = 0;
      prev_rec = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_valid = 0;
         end else begin
            if (tile_req) check("tile_req_vs_cmp_valid", 64'(cmp_valid), 64'd0);
            if (cmp_valid && prev_valid && !prev_ready)
               check("cmp_stable", 64'({cmp_id, cmp_err, cmp_tiles}), 64'(prev_rec));
            if (cmp_valid && cmp_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_record", 64'(cmp_valid), 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("cmp_id", 64'(cmp_id), 64'(e.id));
                  check("cmp_err", 64'(cmp_err), 64'(e.err));
                  check("cmp_tiles", 64'(cmp_tiles), 64'(e.tiles));
               end
            end
            prev_valid = cmp_valid;
            prev_ready = cmp_ready;
            prev_rec = {cmp_id, cmp_err, cmp_tiles};
         end
      end
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tile_req"}, 64'(tile_req), 64'd0);
      check({tag, "_cmp_valid"}, 64'(cmp_valid), 64'd0);
      check({tag, "_job_ready"}, 64'(job_ready), 64'd1);
      check({tag, "_q_level"}, 64'(q_level), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_cmp_fields"}, 64'({cmp_id, cmp_err, cmp_tiles}), 64'd0);
      check({tag, "_cfg_dims"}, 64'({cfg_M, cfg_N, cfg_K, cfg_TM, cfg_TN, cfg_TK}), 64'd0);
      check({tag, "_cfg_base"}, {cfg_baseA, cfg_baseB} | 64'(cfg_baseC), 64'd0);
   endtask

   initial begin : main
      job_t j;
      int t;
      bit any_valid;

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst = 0;
      @(posedge clk); #1;

      // Single directed job.
      j = make_job(0, 8, 1, 0);
      j.m = 16; j.n = 16; j.k = 16; j.tm = 8; j.tn = 8; j.tk = 8;
      push_job(j, 1);
      idle_cycles(1);
      drain();

      // Back-to-back pushes while the first job is still running.
      saw_full = 0;
      push_job(make_job(0, 3, 3, 0), 1);
      j = make_job(0, 0, 0, 0);
      j.tk = '0;
      push_job(j, 1);
      push_job(make_job(0, 4, 0, 0), 1);
      push_job(make_job(1, 0, 0, 0), 1);
      push_job(make_job(2, 0, 0, 0), 1);
      push_job(make_job(0, 5, 2, 0), 1);
      idle_cycles(1);
      check("saw_full", 64'(saw_full), 64'd1);
      drain();

      // Completion held off: record stays, queue keeps accepting, no pop.
      hold_low = 1;
      push_job(make_job(0, 2, 0, 0), 1);
      idle_cycles(1);
      t = 0;
      while (!cmp_valid && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("hold_cmp_valid_seen", 64'(cmp_valid), 64'd1);
      @(posedge clk); #1;
      push_job(make_job(0, 1, 1, 0), 1);
      idle_cycles(1);
      repeat (10) @(negedge clk);
      check("hold_cmp_valid", 64'(cmp_valid), 64'd1);
      check("hold_q_level", 64'(q_level), 64'd1);
      @(posedge clk); #1;
      hold_low = 0;
      drain();

      // Randomized traffic.
      for (int i = 0; i < 25; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r == 0)      j = make_job(0, 0, 0, 1);
         else if (r == 1) j = make_job(1, 0, 0, 0);
         else if (r == 2) j = make_job(2, 0, 0, 0);
         else             j = make_job(0, $urandom_range(0, 9), $urandom_range(0, 3), 0);
         push_job(j, 1);
         if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 4));
      end
      idle_cycles(1);
      drain();
      check("plan_q_empty", 64'(plan_q.size()), 64'd0);

      // Reset in the middle of a running job with two more queued.
      ctrl_en = 0;
      push_job(make_job(0, 1, 0, 0), 0);
      push_job(make_job(0, 1, 0, 0), 0);
      push_job(make_job(0, 1, 0, 0), 0);
      idle_cycles(0);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!tile_req && t < 50);
      check("mid_run_tile_req", 64'(tile_req), 64'd1);
      check("mid_run_q_level", 64'(q_level), 64'd2);
      #2;
      rst = 1;
      #1;
      check_reset_outputs("mid_reset");
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      any_valid = 0;
      repeat (40) begin
         @(negedge clk);
         if (cmp_valid || busy || q_level != 0) any_valid = 1;
      end
      check("post_reset_quiet", 64'(any_valid), 64'd0);
      check("post_reset_q_level", 64'(q_level), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
